io_access_arbiter: RTL and testbench
====================================

Name: io_access_arbiter

Overview:
- Shares the single processor-side peripheral register port (WrEn/RdEn/Address/WrData/RdData) between two masters: M0 = processor load/store path, M1 = debug/DMA master.
- Sits between the masters and the IO register interface that fans out to EIC, BKD and STMR.
- Serialises accesses with round-robin or fixed-priority arbitration, optional bus lock for read-modify-write, and fixed-latency read return.

Parameters:
- RD_LATENCY, 1, cycles from slave RdEn cycle to Sys_RdData valid; legal 1..3.
- FIXED_PRIO, 0, 0 = round-robin between M0/M1; 1 = M0 always wins.

Ports:
- Sys_Clock  in  1  single clock.
- Sys_Reset  in  1  reset, asynchronous, active-low.
- M0_Req, M1_Req  in  1 each  access request; held with its fields stable until Ack.
- M0_Write, M1_Write  in  1 each  1 = write, 0 = read.
- M0_Lock, M1_Lock  in  1 each  keep grant for the next access.
- M0_Address, M1_Address  in  30 each  word address.
- M0_WrData, M1_WrData  in  32 each  write data.
- M0_Ack, M1_Ack  out  1 each  one-cycle pulse: command issued to slave.
- M0_RdValid, M1_RdValid  out  1 each  one-cycle pulse: read data valid.
- M0_RdData, M1_RdData  out  32 each  read data, held until that master's next RdValid.
- Sys_WrEn, Sys_RdEn  out  1 each  slave strobes, one cycle per access.
- Sys_Address  out  30  slave address.
- Sys_WrData  out  32  slave write data.
- Sys_RdData  in  32  slave read data.

Behaviour:
- Reset (Sys_Reset=0, async): state IDLE; all Ack/RdValid/strobes 0; Sys_Address/Sys_WrData 0; RdData regs 0; RR pointer favours M0 next; lock owner cleared.
- FSM states:
  - IDLE: if any Req, pick a winner and register Grant/Write/Address/WrData; go ISSUE.
  - ISSUE: one cycle; Sys_WrEn=Write or Sys_RdEn=~Write; Sys_Address/WrData from registers; Mx_Ack=1 for the granted master. Write goes to IDLE; read goes to WAIT.
  - WAIT: count RD_LATENCY cycles; capture Sys_RdData at the edge ending cycle ISSUE+RD_LATENCY; go RESP.
  - RESP: Mx_RdValid=1 for the granted master, Mx_RdData updated; go IDLE.
- Latency, Req first high in IDLE at cycle t:
  - Ack/strobe at t+1.
  - Read RdValid at t+2+RD_LATENCY.
  - Back-to-back throughput: one write per 2 cycles; one read per 3+RD_LATENCY cycles.
- Strobes off in all states except ISSUE. Master must not change Req fields between Req and Ack. Master drops Req, or presents the next command, the cycle after Ack.
- Arbitration in IDLE:
  - One requester: it wins.
  - Both, FIXED_PRIO=1: M0 wins.
  - Both, FIXED_PRIO=0: the master not granted last wins; pointer updates at every ISSUE.
- Lock:
  - If the granted master's Lock=1 in ISSUE, it becomes lock owner.
  - While a lock owner exists and it requests in IDLE, it wins regardless of policy.
  - Lock is released when the owner issues with Lock=0, or is idle in IDLE with Req=0.
  - Lock never starves the other master beyond the owner's locked sequence.
- Simultaneous events: a Req arriving during ISSUE/WAIT/RESP waits for IDLE. Requests are not queued beyond the single Req level per master.
- Reset mid-access: transaction dropped, no Ack/RdValid issued afterwards; masters must re-request.
- RD_LATENCY outside 1..3 is an elaboration error.

Decomposition:
- Package IO_ArbiterPkg:
  - typedef enum ArbState_t {IDLE, ISSUE, WAIT, RESP}.
  - typedef logic MasterId_t (0 = M0, 1 = M1).
  - constant MAX_RD_LATENCY = 3.
- One sub-module, io_arb_pick: combinational winner selection from Req[1:0], LastGrant, LockOwner/LockValid and FIXED_PRIO; outputs Valid and Winner.

Test Plan:
- M0 write Addr=0x0000010, Data=0xDEADBEEF, M1 idle → Sys_WrEn for 1 cycle at t+1 with those values; M0_Ack same cycle; no RdValid.
- M1 read Addr=0x0000020, RD_LATENCY=2, slave returns 0x12345678 at ISSUE+2 → M1_Ack at t+1; M1_RdValid=1 at t+4 with M1_RdData=0x12345678; M0 outputs quiet.
- Both Req held continuously, FIXED_PRIO=0 → grants alternate M0, M1, M0, M1. Same stimulus with FIXED_PRIO=1 → M1 not granted until M0 drops Req.
- M1 read with Lock=1, then write with Lock=0 (RMW), M0 requesting throughout → both M1 accesses issue consecutively before any M0 Ack.
- Sys_Reset asserted during WAIT of an M0 read → strobes/Ack/RdValid 0 immediately; no RdValid after release; next request served from IDLE normally.
- Request during RESP of the other master → its Ack appears exactly 2 cycles after RESP (IDLE, then ISSUE).

Source files
------------

// File: rtl/io_access_arbiter_pkg.sv
// Shared types for the IO register-port arbiter.
// Holds the FSM state, master id type and read-latency bound.
package IO_ArbiterPkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } ArbState_t;

   // 0 = M0 (load/store path), 1 = M1 (debug/DMA)
   typedef logic MasterId_t;

   localparam int MAX_RD_LATENCY = 3;

endpackage

// File: rtl/io_arb_pick.sv
// Combinational winner selection for the IO register-port arbiter.
// Ports: Req_i (M1,M0 requests), LastGrant_i, LockOwner_i,
//        LockValid_i in; Valid_o (any request), Winner_o out.
module io_arb_pick
   import IO_ArbiterPkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic [1:0] Req_i,
   input  MasterId_t  LastGrant_i,
   input  MasterId_t  LockOwner_i,
   input  logic       LockValid_i,
   output logic       Valid_o,
   output MasterId_t  Winner_o
);

   logic LockHit;
   logic Both;

   // A requesting lock owner overrides both policies
   assign LockHit = LockValid_i && Req_i[LockOwner_i];
   assign Both    = (&Req_i) && !LockHit;

   always_comb begin
      Valid_o  = |Req_i;
      Winner_o = 1'b0;
      unique case (1'b1)
         LockHit: Winner_o = LockOwner_i;
         Both:    Winner_o = FIXED_PRIO ? 1'b0 : ~LastGrant_i;
         default: Winner_o = Req_i[1];
      endcase
   end

endmodule

// File: rtl/io_access_arbiter.sv
// Two-master arbiter for the single peripheral register port.
// Ports: Sys_Clock/Sys_Reset (async, active-low); per master Mx_Req,
//        Mx_Write, Mx_Lock, Mx_Address, Mx_WrData in and Mx_Ack,
//        Mx_RdValid, Mx_RdData out; slave side Sys_WrEn, Sys_RdEn,
//        Sys_Address, Sys_WrData out and Sys_RdData in.
module io_access_arbiter
   import IO_ArbiterPkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int FIXED_PRIO = 0
) (
   input  logic        Sys_Clock,
   input  logic        Sys_Reset,
   input  logic        M0_Req,
   input  logic        M1_Req,
   input  logic        M0_Write,
   input  logic        M1_Write,
   input  logic        M0_Lock,
   input  logic        M1_Lock,
   input  logic [29:0] M0_Address,
   input  logic [29:0] M1_Address,
   input  logic [31:0] M0_WrData,
   input  logic [31:0] M1_WrData,
   output logic        M0_Ack,
   output logic        M1_Ack,
   output logic        M0_RdValid,
   output logic        M1_RdValid,
   output logic [31:0] M0_RdData,
   output logic [31:0] M1_RdData,
   output logic        Sys_WrEn,
   output logic        Sys_RdEn,
   output logic [29:0] Sys_Address,
   output logic [31:0] Sys_WrData,
   input  logic [31:0] Sys_RdData
);

   if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_lat
      $error("io_access_arbiter: RD_LATENCY must be 1..%0d",
             MAX_RD_LATENCY);
   end

   localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

   ArbState_t   State_q, State_d;
   MasterId_t   Grant_q, Grant_d;
   MasterId_t   LastGrant_q, LastGrant_d;
   MasterId_t   LockOwner_q, LockOwner_d;
   logic        LockValid_q, LockValid_d;
   logic        Write_q, Write_d;
   logic        Lock_q, Lock_d;
   logic [29:0] Addr_q, Addr_d;
   logic [31:0] WrData_q, WrData_d;
   logic [1:0]  Cnt_q, Cnt_d;
   logic [31:0] RdData0_q, RdData0_d;
   logic [31:0] RdData1_q, RdData1_d;

   logic [1:0]  Req;
   logic        PickValid;
   MasterId_t   Winner;

   assign Req = {M1_Req, M0_Req};

   io_arb_pick #(
      .FIXED_PRIO (FIXED_PRIO != 0)
   ) u_pick (
      .Req_i       (Req),
      .LastGrant_i (LastGrant_q),
      .LockOwner_i (LockOwner_q),
      .LockValid_i (LockValid_q),
      .Valid_o     (PickValid),
      .Winner_o    (Winner)
   );

   assign Sys_Address = Addr_q;
   assign Sys_WrData  = WrData_q;
   assign M0_RdData   = RdData0_q;
   assign M1_RdData   = RdData1_q;

   always_comb begin
      State_d     = State_q;
      Grant_d     = Grant_q;
      LastGrant_d = LastGrant_q;
      LockOwner_d = LockOwner_q;
      LockValid_d = LockValid_q;
      Write_d     = Write_q;
      Lock_d      = Lock_q;
      Addr_d      = Addr_q;
      WrData_d    = WrData_q;
      Cnt_d       = Cnt_q;
      RdData0_d   = RdData0_q;
      RdData1_d   = RdData1_q;
      M0_Ack      = 1'b0;
      M1_Ack      = 1'b0;
      M0_RdValid  = 1'b0;
      M1_RdValid  = 1'b0;
      Sys_WrEn    = 1'b0;
      Sys_RdEn    = 1'b0;

      unique case (State_q)
         IDLE: begin
            // Owner went quiet: give up the lock
            if (LockValid_q && !Req[LockOwner_q]) begin
               LockValid_d = 1'b0;
            end
            if (PickValid) begin
               Grant_d  = Winner;
               Write_d  = Winner ? M1_Write   : M0_Write;
               Lock_d   = Winner ? M1_Lock    : M0_Lock;
               Addr_d   = Winner ? M1_Address : M0_Address;
               WrData_d = Winner ? M1_WrData  : M0_WrData;
               State_d  = ISSUE;
            end
         end
         ISSUE: begin
            Sys_WrEn    = Write_q;
            Sys_RdEn    = ~Write_q;
            M0_Ack      = (Grant_q == 1'b0);
            M1_Ack      = (Grant_q == 1'b1);
            LastGrant_d = Grant_q;
            if (Lock_q) begin
               LockValid_d = 1'b1;
               LockOwner_d = Grant_q;
            end else if (LockOwner_q == Grant_q) begin
               LockValid_d = 1'b0;
            end
            Cnt_d   = CNT_INIT;
            State_d = Write_q ? IDLE : WAIT;
         end
         WAIT: begin
            if (Cnt_q == 2'd0) begin
               if (Grant_q) begin
                  RdData1_d = Sys_RdData;
               end else begin
                  RdData0_d = Sys_RdData;
               end
               State_d = RESP;
            end else begin
               Cnt_d = Cnt_q - 2'd1;
            end
         end
         RESP: begin
            M0_RdValid = (Grant_q == 1'b0);
            M1_RdValid = (Grant_q == 1'b1);
            State_d    = IDLE;
         end
         default: State_d = IDLE;
      endcase
   end

   always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
      if (!Sys_Reset) begin
         State_q     <= IDLE;
         Grant_q     <= 1'b0;
         // Points at M1 so M0 wins the first contested round
         LastGrant_q <= 1'b1;
         LockOwner_q <= 1'b0;
         LockValid_q <= 1'b0;
         Write_q     <= 1'b0;
         Lock_q      <= 1'b0;
         Addr_q      <= '0;
         WrData_q    <= '0;
         Cnt_q       <= '0;
         RdData0_q   <= '0;
         RdData1_q   <= '0;
      end else begin
         State_q     <= State_d;
         Grant_q     <= Grant_d;
         LastGrant_q <= LastGrant_d;
         LockOwner_q <= LockOwner_d;
         LockValid_q <= LockValid_d;
         Write_q     <= Write_d;
         Lock_q      <= Lock_d;
         Addr_q      <= Addr_d;
         WrData_q    <= WrData_d;
         Cnt_q       <= Cnt_d;
         RdData0_q   <= RdData0_d;
         RdData1_q   <= RdData1_d;
      end
   end

endmodule

// File: tb/tb_io_access_arbiter.sv
// Randomized bench for io_access_arbiter in two configurations:
// round-robin with RD_LATENCY=2 and fixed priority with RD_LATENCY=1.
module tb_io_access_arbiter;

   localparam int NCYC = 1500;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Slave read data is a known function of the cycle number
   function automatic logic [31:0] slv_data(input int g, input int c);
      return 32'h5A5A_0000 ^ (32'(c) * 32'h0100_0193) ^ (32'(g) << 28);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_cfg
      localparam int RL = (g == 0) ? 2 : 1;
      localparam int FP = (g == 0) ? 0 : 1;

      logic        rst_n;
      logic [1:0]  req, wr, lk;
      logic [29:0] addr [2];
      logic [31:0] wdat [2];
      logic        ack0, ack1, rdv0, rdv1, wren, rden;
      logic [31:0] rdd0, rdd1, swd, srd;
      logic [29:0] sadr;
      logic        done_g;

      // bench-side model of the bus schedule
      int          free_c, iss_c, rsp_c;
      logic        gnt, iss_wr, last, lk_v, lk_o, rst_rel, did_rst;
      logic [29:0] iss_adr;
      logic [31:0] iss_dat, exp_rd;
      logic [31:0] hold [2];
      logic [1:0]  nreq, nwr, nlk;
      logic [29:0] naddr [2];
      logic [31:0] nwdat [2];
      logic [5:0]  exp_s;
      string       pfx;

      io_access_arbiter #(
         .RD_LATENCY (RL),
         .FIXED_PRIO (FP)
      ) u_dut (
         .Sys_Clock   (clk),
         .Sys_Reset   (rst_n),
         .M0_Req      (req[0]),
         .M1_Req      (req[1]),
         .M0_Write    (wr[0]),
         .M1_Write    (wr[1]),
         .M0_Lock     (lk[0]),
         .M1_Lock     (lk[1]),
         .M0_Address  (addr[0]),
         .M1_Address  (addr[1]),
         .M0_WrData   (wdat[0]),
         .M1_WrData   (wdat[1]),
         .M0_Ack      (ack0),
         .M1_Ack      (ack1),
         .M0_RdValid  (rdv0),
         .M1_RdValid  (rdv1),
         .M0_RdData   (rdd0),
         .M1_RdData   (rdd1),
         .Sys_WrEn    (wren),
         .Sys_RdEn    (rden),
         .Sys_Address (sadr),
         .Sys_WrData  (swd),
         .Sys_RdData  (srd)
      );

      initial begin : stim
         done_g = 1'b0;
         pfx    = $sformatf("cfg%0d", g);
         rst_n  = 1'b0;
         req = '0; wr = '0; lk = '0;
         nreq = '0; nwr = '0; nlk = '0;
         for (int m = 0; m < 2; m++) begin
            addr[m] = '0; wdat[m] = '0; naddr[m] = '0; nwdat[m] = '0;
            hold[m] = '0;
         end
         srd = '0;
         repeat (2) @(posedge clk);
         #1;
         chk({pfx, " rst_strobes"},
             {58'd0, ack0, ack1, wren, rden, rdv0, rdv1}, 64'd0);
         chk({pfx, " rst_addr"}, {34'd0, sadr}, 64'd0);
         chk({pfx, " rst_wdata"}, {32'd0, swd}, 64'd0);
         chk({pfx, " rst_rdata"}, {rdd0, rdd1}, 64'd0);
         @(negedge clk);
         rst_n   = 1'b1;
         free_c  = 0;
         iss_c   = -1;
         rsp_c   = -1;
         gnt     = 1'b0;
         iss_wr  = 1'b0;
         iss_adr = '0;
         iss_dat = '0;
         exp_rd  = '0;
         last    = 1'b1;
         lk_v    = 1'b0;
         lk_o    = 1'b0;
         rst_rel = 1'b0;
         did_rst = 1'b0;

         for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            req = nreq; wr = nwr; lk = nlk;
            for (int m = 0; m < 2; m++) begin
               addr[m] = naddr[m];
               wdat[m] = nwdat[m];
            end
            srd = slv_data(g, c);
            @(negedge clk);

            // expected outputs for this cycle
            if (c == rsp_c) hold[gnt] = exp_rd;
            exp_s = {c == iss_c && !gnt, c == iss_c && gnt,
                     c == iss_c && iss_wr, c == iss_c && !iss_wr,
                     c == rsp_c && !gnt, c == rsp_c && gnt};
            chk($sformatf("%s c%0d strobes", pfx, c),
                {58'd0, ack0, ack1, wren, rden, rdv0, rdv1},
                {58'd0, exp_s});
            if (c == iss_c) begin
               chk($sformatf("%s c%0d addr", pfx, c),
                   {34'd0, sadr}, {34'd0, iss_adr});
               if (iss_wr)
                  chk($sformatf("%s c%0d wdata", pfx, c),
                      {32'd0, swd}, {32'd0, iss_dat});
            end
            chk($sformatf("%s c%0d rdata", pfx, c),
                {rdd0, rdd1}, {hold[0], hold[1]});

            // bus free: apply lock release and arbitration rules
            if (c >= free_c) begin
               if (lk_v && !req[lk_o]) lk_v = 1'b0;
               if (req != 2'b00) begin
                  if (lk_v && req[lk_o])  gnt = lk_o;
                  else if (&req)          gnt = (FP != 0) ? 1'b0 : ~last;
                  else                    gnt = req[1];
                  iss_c   = c + 1;
                  iss_wr  = wr[gnt];
                  iss_adr = addr[gnt];
                  iss_dat = wdat[gnt];
                  last    = gnt;
                  if (lk[gnt]) begin
                     lk_v = 1'b1;
                     lk_o = gnt;
                  end else if (lk_o == gnt) begin
                     lk_v = 1'b0;
                  end
                  if (iss_wr) begin
                     free_c = c + 2;
                  end else begin
                     rsp_c  = c + 2 + RL;
                     free_c = c + 3 + RL;
                     exp_rd = slv_data(g, c + 1 + RL);
                  end
               end
            end

            if (!did_rst && c > NCYC / 2 && iss_c >= 0 &&
                c > iss_c && c < rsp_c) begin
               // reset in the middle of a read wait
               did_rst = 1'b1;
               rst_n   = 1'b0;
               #1;
               chk($sformatf("%s c%0d midrst_strobes", pfx, c),
                   {58'd0, ack0, ack1, wren, rden, rdv0, rdv1}, 64'd0);
               chk($sformatf("%s c%0d midrst_rdata", pfx, c),
                   {rdd0, rdd1}, 64'd0);
               iss_c   = -1;
               rsp_c   = -1;
               free_c  = c + 2;
               last    = 1'b1;
               lk_v    = 1'b0;
               hold[0] = '0;
               hold[1] = '0;
               nreq    = '0;
               rst_rel = 1'b1;
            end else begin
               if (rst_rel) begin
                  rst_n   = 1'b1;
                  rst_rel = 1'b0;
               end
               nreq = req;
               if (c == iss_c) nreq[gnt] = 1'b0;
               for (int m = 0; m < 2; m++) begin
                  if (!nreq[m] && $urandom_range(0, 99) < 55) begin
                     nreq[m]  = 1'b1;
                     nwr[m]   = 1'($urandom_range(0, 1));
                     nlk[m]   = ($urandom_range(0, 3) == 0);
                     naddr[m] = 30'($urandom);
                     nwdat[m] = $urandom;
                  end
               end
            end
         end
         nreq = '0;
         done_g = 1'b1;
      end
   end

   initial begin
      wait (g_cfg[0].done_g === 1'b1 && g_cfg[1].done_g === 1'b1);
      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
